feeding_controller: RTL and testbench

- Behavioural stage directly downstream of the nourishment system.
- Consumes hungry/starving and a food-present stimulus, and decides when the creature seeks food, eats and digests.
- Drives the 8-bit action vector that the nourishment regulator reads. This closes the hunger loop: eating raises glucose, which clears hungry.
- All timing advances on a slow one-cycle tick strobe, not on every clock.

---
 rtl/feeding_pkg.sv | 29 ++
 rtl/feeding_controller_tick_timer.sv | 43 ++++
 rtl/feeding_controller.sv | 140 ++++++++++++++
 tb/tb_feeding_controller.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/feeding_pkg.sv
// Shared types for the feeding behaviour: state encoding and action vector bit positions.
// The nourishment regulator imports the same action indices from here.
package feeding_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEEK   = 2'd1,
        EAT    = 2'd2,
        DIGEST = 2'd3
    } feed_state_e;

    localparam int ACT_EAT       = 0;
    localparam int ACT_SEEK_FOOD = 1;
    localparam int ACT_REST      = 2;

    // Exactly one action bit per non-idle state; bits 7:3 stay zero.
    function automatic logic [7:0] action_of(input feed_state_e s);
        logic [7:0] a;
        a = 8'h00;
        case (s)
            SEEK:    a[ACT_SEEK_FOOD] = 1'b1;
            EAT:     a[ACT_EAT]       = 1'b1;
            DIGEST:  a[ACT_REST]      = 1'b1;
            default: a = 8'h00;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/feeding_controller_tick_timer.sv
// Tick-gated up/down counter with an immediate load, saturating at zero and at max_val.
// Shared by the drive controllers; load takes priority and ignores tick.
module tick_timer #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             inc,
    input  logic             dec,
    input  logic [CNT_W-1:0] max_val,
    output logic [CNT_W-1:0] count,
    output logic             is_zero
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (tick && inc && (count_q < max_val)) begin
            count_d = count_q + CNT_W'(1);
        end else if (tick && dec && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count   = count_q;
    assign is_zero = (count_q == '0);

endmodule

// File: rtl/feeding_controller.sv
// Feeding behaviour FSM: seeks food when hungry, eats, then rests; drives the action vector
// read by the nourishment regulator. Timers advance only on the slow tick strobe.
module feeding_controller
    import feeding_pkg::*;
#(
    parameter int EAT_TICKS    = 8,
    parameter int DIGEST_TICKS = 16,
    parameter int SEEK_TIMEOUT = 32,
    parameter int CNT_W        = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       hungry,
    input  logic       starving,
    input  logic       food_present,
    input  logic       sleeping,
    output logic [7:0] action,
    output logic       gave_up,
    output logic [1:0] state_dbg
);

    localparam logic [CNT_W-1:0] EAT_LOAD    = CNT_W'(EAT_TICKS);
    localparam logic [CNT_W-1:0] DIGEST_LOAD = CNT_W'(DIGEST_TICKS);
    localparam logic [CNT_W-1:0] SEEK_MAX    = CNT_W'(SEEK_TIMEOUT);

    feed_state_e      state_q, state_d;
    logic             gave_up_q, gave_up_d;

    logic             t_load, t_inc, t_dec;
    logic [CNT_W-1:0] t_load_val;
    logic [CNT_W-1:0] timer;
    logic             timer_zero;
    logic             timer_last;
    logic [CNT_W:0]   seek_next;
    logic             seek_expired;

    // One extra bit so timer+1 can reach SEEK_TIMEOUT even when it equals 2**CNT_W-1.
    assign seek_next    = {1'b0, timer} + (CNT_W+1)'(1);
    assign seek_expired = (seek_next >= {1'b0, SEEK_MAX});
    // The tick that would bring the count to zero (or finds it already there) ends the state.
    assign timer_last   = timer_zero || (timer == CNT_W'(1));

    always_comb begin
        state_d    = state_q;
        gave_up_d  = 1'b0;
        t_load     = 1'b0;
        t_load_val = '0;
        t_inc      = 1'b0;
        t_dec      = 1'b0;
        case (state_q)
            IDLE: begin
                if (hungry && !sleeping) begin
                    state_d = SEEK;
                    t_load  = 1'b1;
                end
            end
            SEEK: begin
                if (food_present) begin
                    state_d    = EAT;
                    t_load     = 1'b1;
                    t_load_val = EAT_LOAD;
                end else if ((sleeping && !starving) || !hungry) begin
                    state_d = IDLE;
                    t_load  = 1'b1;
                end else if (tick) begin
                    if (!starving && seek_expired) begin
                        state_d   = IDLE;
                        t_load    = 1'b1;
                        gave_up_d = 1'b1;
                    end else begin
                        t_inc = 1'b1;
                    end
                end
            end
            EAT: begin
                if (!food_present) begin
                    state_d    = hungry ? SEEK : DIGEST;
                    t_load     = 1'b1;
                    t_load_val = hungry ? '0 : DIGEST_LOAD;
                end else if (tick) begin
                    if (timer_last) begin
                        state_d    = DIGEST;
                        t_load     = 1'b1;
                        t_load_val = DIGEST_LOAD;
                    end else begin
                        t_dec = 1'b1;
                    end
                end
            end
            DIGEST: begin
                if (starving) begin
                    state_d = SEEK;
                    t_load  = 1'b1;
                end else if (tick) begin
                    if (timer_last) begin
                        state_d = IDLE;
                        t_load  = 1'b1;
                    end else begin
                        t_dec = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                t_load  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gave_up_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gave_up_q <= gave_up_d;
        end
    end

    tick_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .load     (t_load),
        .load_val (t_load_val),
        .inc      (t_inc),
        .dec      (t_dec),
        .max_val  (SEEK_MAX),
        .count    (timer),
        .is_zero  (timer_zero)
    );

    assign action    = action_of(state_q);
    assign gave_up   = gave_up_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_feeding_controller.sv
// Self-checking bench for feeding_controller: each scenario task pushes the expected
// {state, gave_up, action} for a clock and compares it against the DUT after that edge.
module tb_feeding_controller;
  import feeding_pkg::*;

  logic       clk = 1'b0;
  logic       rst, tick, hungry, starving, food_present, sleeping;
  logic [7:0] action;
  logic       gave_up;
  logic [1:0] state_dbg;

  logic [10:0] exp_q[$];
  logic [10:0] got, e;
  int total = 0;
  int bad = 0;

  feeding_controller dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .hungry       (hungry),
    .starving     (starving),
    .food_present (food_present),
    .sleeping     (sleeping),
    .action       (action),
    .gave_up      (gave_up),
    .state_dbg    (state_dbg)
  );

  always #5 clk = ~clk;

  // reference decode: IDLE 00, SEEK 02, EAT 01, DIGEST 04
  function automatic logic [10:0] exp_of(input logic [1:0] st, input logic g);
    logic [7:0] a;
    case (st)
      2'd0: a = 8'h00;
      2'd1: a = 8'h02;
      2'd2: a = 8'h01;
      default: a = 8'h04;
    endcase
    return {st, g, a};
  endfunction

  // one clock; outputs are stable 1ns after the edge
  task automatic clk1(input logic t);
    tick = t;
    @(posedge clk);
    #1;
    tick = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick = 1'b0; hungry = 1'b0; starving = 1'b0;
    food_present = 1'b0; sleeping = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(exp_of(IDLE, 1'b0)); clk1(1'b0);
      got = {state_dbg, gave_up, action}; e = exp_q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL reset_init: got=%h want=%h", got, e); end
    end
    rst = 1'b0;
    // get into EAT and run 3 ticks (timer 8 -> 5), then reset
    hungry = 1'b1;
    exp_q.push_back(exp_of(SEEK, 1'b0)); clk1(1'b0);
    got = {state_dbg, gave_up, action}; e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL reset_seek: got=%h want=%h", got, e); end
    food_present = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(exp_of(EAT, 1'b0)); clk1(i != 0);
      got = {state_dbg, gave_up, action}; e = exp_q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL reset_eat: got=%h want=%h", got, e); end
    end
    rst = 1'b1;
    exp_q.push_back(exp_of(IDLE, 1'b0)); clk1(1'b1);
    got = {state_dbg, gave_up, action}; e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL reset_mid_eat: got=%h want=%h", got, e); end
    rst = 1'b0; hungry = 1'b0; food_present = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(exp_of(IDLE, 1'b0)); clk1(1'b1);
      got = {state_dbg, gave_up, action}; e = exp_q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL reset_quiet: got=%h want=%h", got, e); end
    end
  endtask

  // tick every 4 clocks through SEEK -> EAT -> DIGEST -> IDLE
  task automatic test_full_meal();
    hungry = 1'b1;
    exp_q.push_back(exp_of(SEEK, 1'b0)); clk1(1'b0);
    got = {state_dbg, gave_up, action}; e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL meal_seek: got=%h want=%h", got, e); end
    for (int c = 0; c < 8; c++) begin
      exp_q.push_back(exp_of(SEEK, 1'b0)); clk1(c % 4 == 3);
      got = {state_dbg, gave_up, action}; e = exp_q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL meal_seek_hold: got=%h want=%h", got, e); end
    end
    food_present = 1'b1;
    exp_q.push_back(exp_of(EAT, 1'b0)); clk1(1'b0);
    got = {state_dbg, gave_up, action}; e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL meal_eat_entry: got=%h want=%h", got, e); end
    for (int k = 0; k < 8; k++) begin
      for (int c = 0; c < 4; c++) begin
        exp_q.push_back(exp_of((k == 7 && c == 3) ? DIGEST : EAT, 1'b0)); clk1(c == 3);
        got = {state_dbg, gave_up, action}; e = exp_q.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL meal_eat k=%0d c=%0d: got=%h want=%h", k, c, got, e); end
      end
    end
    hungry = 1'b0; food_present = 1'b0;
    for (int k = 0; k < 16; k++) begin
      for (int c = 0; c < 4; c++) begin
        exp_q.push_back(exp_of((k == 15 && c == 3) ? IDLE : DIGEST, 1'b0)); clk1(c == 3);
        got = {state_dbg, gave_up, action}; e = exp_q.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL meal_digest k=%0d c=%0d: got=%h want=%h", k, c, got, e); end
      end
    end
  endtask

  task automatic test_timeout();
    hungry = 1'b1;
    exp_q.push_back(exp_of(SEEK, 1'b0)); clk1(1'b0);
    got = {state_dbg, gave_up, action}; e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL timeout_entry: got=%h want=%h", got, e); end
    for (int k = 1; k <= 32; k++) begin
      exp_q.push_back(k == 32 ? exp_of(IDLE, 1'b1) : exp_of(SEEK, 1'b0)); clk1(1'b1);
      got = {state_dbg, gave_up, action}; e = exp_q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL timeout tick=%0d: got=%h want=%h", k, got, e); end
    end
    exp_q.push_back(exp_of(SEEK, 1'b0)); clk1(1'b0);
    got = {state_dbg, gave_up, action}; e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL timeout_reenter: got=%h want=%h", got, e); end
    hungry = 1'b0;
    exp_q.push_back(exp_of(IDLE, 1'b0)); clk1(1'b0);
    got = {state_dbg, gave_up, action}; e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL timeout_unhungry: got=%h want=%h", got, e); end
  endtask

  // starving SEEK never times out; food on a tick cycle loads the full EAT count
  task automatic test_starving();
    hungry = 1'b1; starving = 1'b1;
    exp_q.push_back(exp_of(SEEK, 1'b0)); clk1(1'b0);
    got = {state_dbg, gave_up, action}; e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL starve_entry: got=%h want=%h", got, e); end
    for (int k = 0; k < 100; k++) begin
      exp_q.push_back(exp_of(SEEK, 1'b0)); clk1(1'b1);
      got = {state_dbg, gave_up, action}; e = exp_q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL starve_hold tick=%0d: got=%h want=%h", k, got, e); end
    end
    food_present = 1'b1;
    exp_q.push_back(exp_of(EAT, 1'b0)); clk1(1'b1);
    got = {state_dbg, gave_up, action}; e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL starve_eat: got=%h want=%h", got, e); end
    for (int k = 1; k <= 8; k++) begin
      exp_q.push_back(exp_of(k == 8 ? DIGEST : EAT, 1'b0)); clk1(1'b1);
      got = {state_dbg, gave_up, action}; e = exp_q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL starve_eat_load tick=%0d: got=%h want=%h", k, got, e); end
    end
    starving = 1'b0; hungry = 1'b0; food_present = 1'b0;
    for (int k = 0; k < 6; k++) begin
      exp_q.push_back(exp_of(DIGEST, 1'b0)); clk1(1'b1);
      got = {state_dbg, gave_up, action}; e = exp_q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL digest_run tick=%0d: got=%h want=%h", k, got, e); end
    end
    starving = 1'b1; hungry = 1'b1;
    exp_q.push_back(exp_of(SEEK, 1'b0)); clk1(1'b0);
    got = {state_dbg, gave_up, action}; e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL digest_abort: got=%h want=%h", got, e); end
    starving = 1'b0; hungry = 1'b0;
    exp_q.push_back(exp_of(IDLE, 1'b0)); clk1(1'b0);
    got = {state_dbg, gave_up, action}; e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL starve_exit: got=%h want=%h", got, e); end
  endtask

  task automatic test_food_removed();
    for (int pass = 0; pass < 2; pass++) begin
      hungry = 1'b1;
      exp_q.push_back(exp_of(SEEK, 1'b0)); clk1(1'b0);
      got = {state_dbg, gave_up, action}; e = exp_q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL removed_seek p=%0d: got=%h want=%h", pass, got, e); end
      food_present = 1'b1;
      for (int k = 0; k < 4; k++) begin
        exp_q.push_back(exp_of(EAT, 1'b0)); clk1(k != 0);
        got = {state_dbg, gave_up, action}; e = exp_q.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL removed_eat p=%0d: got=%h want=%h", pass, got, e); end
      end
      food_present = 1'b0;
      hungry = (pass == 0);
      exp_q.push_back(exp_of(pass == 0 ? SEEK : DIGEST, 1'b0)); clk1(1'b0);
      got = {state_dbg, gave_up, action}; e = exp_q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL removed_exit p=%0d: got=%h want=%h", pass, got, e); end
      // SEEK restarted at 0 must last 32 ticks; DIGEST must last 16
      for (int k = 1; k <= (pass == 0 ? 32 : 16); k++) begin
        if (pass == 0) exp_q.push_back(k == 32 ? exp_of(IDLE, 1'b1) : exp_of(SEEK, 1'b0));
        else exp_q.push_back(exp_of(k == 16 ? IDLE : DIGEST, 1'b0));
        clk1(1'b1);
        got = {state_dbg, gave_up, action}; e = exp_q.pop_front(); total++;
        if (got !== e) begin bad++; $display("FAIL removed_run p=%0d tick=%0d: got=%h want=%h", pass, k, got, e); end
      end
      hungry = 1'b0;
      exp_q.push_back(exp_of(IDLE, 1'b0)); clk1(1'b0);
      got = {state_dbg, gave_up, action}; e = exp_q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL removed_idle p=%0d: got=%h want=%h", pass, got, e); end
    end
  endtask

  task automatic test_sleep();
    hungry = 1'b1; sleeping = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(exp_of(IDLE, 1'b0)); clk1(k[0]);
      got = {state_dbg, gave_up, action}; e = exp_q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL sleep_idle: got=%h want=%h", got, e); end
    end
    sleeping = 1'b0;
    exp_q.push_back(exp_of(SEEK, 1'b0)); clk1(1'b0);
    got = {state_dbg, gave_up, action}; e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL sleep_wake: got=%h want=%h", got, e); end
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back(exp_of(SEEK, 1'b0)); clk1(1'b1);
      got = {state_dbg, gave_up, action}; e = exp_q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL sleep_seek: got=%h want=%h", got, e); end
    end
    sleeping = 1'b1;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(exp_of(IDLE, 1'b0)); clk1(1'b1);
      got = {state_dbg, gave_up, action}; e = exp_q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL sleep_seek_exit: got=%h want=%h", got, e); end
    end
    sleeping = 1'b0; hungry = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_meal();
    test_timeout();
    test_starving();
    test_food_removed();
    test_sleep();
    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL scoreboard_leftover: got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
